// File: rtl/output_layer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : output_layer_pkg
// Brief    : AXI constants and write-FSM state type shared by the writer.
// Revision : 1.0 - initial parametrised release
// ============================================================================
package output_layer_pkg;

   localparam logic [1:0] BURST_INCR       = 2'b01;
   localparam logic [3:0] CACHE_BUFFERABLE = 4'b0011;
   localparam logic [1:0] RESP_OKAY        = 2'b00;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_AW   = 2'd1,
      ST_W    = 2'd2,
      ST_B    = 2'd3
   } wr_state_t;

   function automatic logic [31:0] min_u32(input logic [31:0] a, input logic [31:0] b);
      return (a < b) ? a : b;
   endfunction

endpackage
`default_nettype wire

// File: rtl/output_layer_beat_fifo.sv
`default_nettype none
// ============================================================================
// Module   : output_layer_beat_fifo
// Brief    : Synchronous show-ahead FIFO holding packed AXI beats, with count.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module output_layer_beat_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_data,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_data,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_push;
   logic             w_pop;

   assign o_full  = (r_count == CNT_W'(DEPTH));
   assign o_empty = (r_count == '0);
   assign o_count = r_count;
   assign o_data  = r_mem[r_rd_ptr];
   assign w_push  = i_push && !o_full;
   assign w_pop   = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; validity is tracked by the pointers alone.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= i_data;
   end

endmodule
`default_nettype wire

// File: rtl/output_layer_writer.sv
`default_nettype none
// ============================================================================
// Module   : output_layer_writer
// Brief    : Packs a pixel stream into AXI beats and writes it to DDR in bursts.
// Revision : 1.0 - initial parametrised release
// ============================================================================
module output_layer_writer #(
   parameter int C_S_AXI_ID_WIDTH   = 3,
   parameter int C_S_AXI_ADDR_WIDTH = 32,
   parameter int C_S_AXI_DATA_WIDTH = 64,
   parameter int C_S_AXI_BURST_LEN  = 8,
   parameter int PIX_WIDTH          = 8,
   parameter int DIM_WIDTH          = 10,
   parameter int FIFO_DEPTH         = 16
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            start,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   base_addr,
   input  logic [DIM_WIDTH-1:0]            no_of_layers,
   input  logic [DIM_WIDTH-1:0]            row_size,
   input  logic [DIM_WIDTH-1:0]            col_size,
   input  logic [PIX_WIDTH-1:0]            s_data,
   input  logic                            s_valid,
   output logic                            s_ready,
   output logic                            busy,
   output logic                            done,
   output logic                            error,
   output logic [C_S_AXI_ID_WIDTH-1:0]     M_axi_awid,
   output logic [C_S_AXI_ADDR_WIDTH-1:0]   M_axi_awaddr,
   output logic [7:0]                      M_axi_awlen,
   output logic [2:0]                      M_axi_awsize,
   output logic [1:0]                      M_axi_awburst,
   output logic                            M_axi_awlock,
   output logic [3:0]                      M_axi_awcache,
   output logic [2:0]                      M_axi_awprot,
   output logic [3:0]                      M_axi_awqos,
   output logic                            M_axi_awvalid,
   input  logic                            M_axi_awready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   M_axi_wdata,
   output logic [C_S_AXI_DATA_WIDTH/8-1:0] M_axi_wstrb,
   output logic                            M_axi_wlast,
   output logic                            M_axi_wvalid,
   input  logic                            M_axi_wready,
   input  logic [1:0]                      M_axi_bresp,
   input  logic                            M_axi_bvalid,
   output logic                            M_axi_bready
);

   import output_layer_pkg::*;

   localparam int ADDR_W     = C_S_AXI_ADDR_WIDTH;
   localparam int DATA_W     = C_S_AXI_DATA_WIDTH;
   localparam int BEAT_BYTES = DATA_W / 8;
   localparam int BEAT_SHIFT = $clog2(BEAT_BYTES);
   localparam int CNT_W      = $clog2(FIFO_DEPTH) + 1;

   // Frame configuration
   logic                  r_busy;
   logic                  r_done;
   logic                  r_error;
   logic [ADDR_W-1:0]     r_base;
   logic [DIM_WIDTH-1:0]  r_layers;
   logic [DIM_WIDTH-1:0]  r_rows;
   logic [DIM_WIDTH-1:0]  r_col;

   // Input side
   logic [DIM_WIDTH-1:0]  r_in_col;
   logic [DIM_WIDTH-1:0]  r_in_layer;
   logic [DIM_WIDTH-1:0]  r_in_row;
   logic                  r_in_done;
   logic [DATA_W-1:0]     r_pack;
   logic [BEAT_SHIFT-1:0] r_pack_idx;

   // Write side
   wr_state_t             r_state;
   logic [DIM_WIDTH-1:0]  r_wr_layer;
   logic [DIM_WIDTH-1:0]  r_wr_row;
   logic [ADDR_W-1:0]     r_seg_off;
   logic [DIM_WIDTH-1:0]  r_seg_left;
   logic [4:0]            r_len;
   logic [4:0]            r_wbeat;
   logic                  r_awvalid;
   logic [ADDR_W-1:0]     r_awaddr;
   logic [7:0]            r_awlen;

   logic                  w_accept;
   logic                  w_push;
   logic                  w_pop;
   logic [DATA_W-1:0]     w_beat;
   logic [DATA_W-1:0]     w_fifo_data;
   logic [CNT_W-1:0]      w_fifo_count;
   logic                  w_fifo_full;
   logic                  w_fifo_empty;
   logic [DIM_WIDTH-1:0]  w_seg_beats;
   logic [ADDR_W-1:0]     w_seg_idx;
   logic [ADDR_W-1:0]     w_cur_addr;
   logic [12:0]           w_page_room;
   logic [4:0]            w_len;
   logic                  w_fifo_ok;
   logic                  w_wvalid;
   logic                  w_wlast;
   logic                  w_seg_end;
   logic                  w_last_seg;

   assign s_ready  = r_busy && !r_in_done && !w_fifo_full;
   assign w_accept = s_valid && s_ready;
   assign w_push   = w_accept && (&r_pack_idx);

   always_comb begin
      w_beat = r_pack;
      w_beat[{r_pack_idx, 3'b000} +: 8] = s_data;
   end

   // Segment address is rebuilt from the write-side layer/row indices, so a
   // segment change needs no separate address reload step.
   assign w_seg_beats = r_col >> BEAT_SHIFT;
   assign w_seg_idx   = ADDR_W'(r_wr_layer) * ADDR_W'(r_rows) + ADDR_W'(r_wr_row);
   assign w_cur_addr  = r_base + w_seg_idx * ADDR_W'(r_col) + r_seg_off;
   assign w_page_room = 13'h1000 - {1'b0, w_cur_addr[11:0]};
   assign w_len       = 5'(min_u32(32'(C_S_AXI_BURST_LEN),
                                   min_u32(32'(r_seg_left), 32'(w_page_room >> BEAT_SHIFT))));
   assign w_fifo_ok   = (32'(w_fifo_count) >= 32'(w_len));

   assign w_wvalid   = (r_state == ST_W) && !w_fifo_empty;
   assign w_wlast    = (r_state == ST_W) && (r_wbeat == r_len - 1'b1);
   assign w_pop      = w_wvalid && M_axi_wready;
   assign w_seg_end  = (r_seg_left == DIM_WIDTH'(r_len));
   assign w_last_seg = (r_wr_layer == r_layers - 1'b1) && (r_wr_row == r_rows - 1'b1);

   output_layer_beat_fifo #(
      .WIDTH (DATA_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset_n (reset_n),
      .i_push  (w_push),
      .i_data  (w_beat),
      .i_pop   (w_pop),
      .o_data  (w_fifo_data),
      .o_count (w_fifo_count),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_base     <= '0;
         r_layers   <= '0;
         r_rows     <= '0;
         r_col      <= '0;
         r_in_col   <= '0;
         r_in_layer <= '0;
         r_in_row   <= '0;
         r_in_done  <= 1'b0;
         r_pack     <= '0;
         r_pack_idx <= '0;
         r_state    <= ST_IDLE;
         r_wr_layer <= '0;
         r_wr_row   <= '0;
         r_seg_off  <= '0;
         r_seg_left <= '0;
         r_len      <= '0;
         r_wbeat    <= '0;
         r_awvalid  <= 1'b0;
         r_awaddr   <= '0;
         r_awlen    <= '0;
      end else begin
         r_done <= 1'b0;
         if (start && !r_busy) begin
            r_base     <= base_addr;
            r_layers   <= no_of_layers;
            r_rows     <= row_size;
            r_col      <= col_size;
            r_error    <= 1'b0;
            r_in_col   <= '0;
            r_in_layer <= '0;
            r_in_row   <= '0;
            r_in_done  <= 1'b0;
            r_pack_idx <= '0;
            r_state    <= ST_IDLE;
            r_awvalid  <= 1'b0;
            r_wr_layer <= '0;
            r_wr_row   <= '0;
            r_seg_off  <= '0;
            r_seg_left <= col_size >> BEAT_SHIFT;
            if (no_of_layers == '0 || row_size == '0)
               r_done <= 1'b1;
            else
               r_busy <= 1'b1;
         end else begin
            // Pixel counters nest col -> layer -> row, matching arrival order.
            if (w_accept) begin
               r_pack     <= w_beat;
               r_pack_idx <= r_pack_idx + 1'b1;
               if (r_in_col == r_col - 1'b1) begin
                  r_in_col <= '0;
                  if (r_in_layer == r_layers - 1'b1) begin
                     r_in_layer <= '0;
                     if (r_in_row == r_rows - 1'b1) begin
                        r_in_row  <= '0;
                        r_in_done <= 1'b1;
                     end else begin
                        r_in_row <= r_in_row + 1'b1;
                     end
                  end else begin
                     r_in_layer <= r_in_layer + 1'b1;
                  end
               end else begin
                  r_in_col <= r_in_col + 1'b1;
               end
            end

            case (r_state)
               ST_IDLE: begin
                  if (r_busy && w_fifo_ok) begin
                     r_len     <= w_len;
                     r_awlen   <= 8'(w_len) - 8'd1;
                     r_awaddr  <= w_cur_addr;
                     r_awvalid <= 1'b1;
                     r_wbeat   <= '0;
                     r_state   <= ST_AW;
                  end
               end
               ST_AW: begin
                  if (M_axi_awready) begin
                     r_awvalid <= 1'b0;
                     r_state   <= ST_W;
                  end
               end
               ST_W: begin
                  if (w_pop) begin
                     r_wbeat <= r_wbeat + 1'b1;
                     if (w_wlast) r_state <= ST_B;
                  end
               end
               ST_B: begin
                  if (M_axi_bvalid) begin
                     if (M_axi_bresp != RESP_OKAY) r_error <= 1'b1;
                     r_state <= ST_IDLE;
                     if (w_seg_end) begin
                        r_seg_off  <= '0;
                        r_seg_left <= w_seg_beats;
                        if (w_last_seg) begin
                           r_busy <= 1'b0;
                           r_done <= 1'b1;
                        end else if (r_wr_layer == r_layers - 1'b1) begin
                           r_wr_layer <= '0;
                           r_wr_row   <= r_wr_row + 1'b1;
                        end else begin
                           r_wr_layer <= r_wr_layer + 1'b1;
                        end
                     end else begin
                        r_seg_off  <= r_seg_off + (ADDR_W'(r_len) << BEAT_SHIFT);
                        r_seg_left <= r_seg_left - DIM_WIDTH'(r_len);
                     end
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign busy  = r_busy;
   assign done  = r_done;
   assign error = r_error;

   assign M_axi_awid    = '0;
   assign M_axi_awaddr  = r_awaddr;
   assign M_axi_awlen   = r_awlen;
   assign M_axi_awsize  = 3'(BEAT_SHIFT);
   assign M_axi_awburst = BURST_INCR;
   assign M_axi_awlock  = 1'b0;
   assign M_axi_awcache = CACHE_BUFFERABLE;
   assign M_axi_awprot  = 3'b000;
   assign M_axi_awqos   = 4'b0000;
   assign M_axi_awvalid = r_awvalid;

   assign M_axi_wdata  = w_fifo_data;
   assign M_axi_wstrb  = '1;
   assign M_axi_wlast  = w_wlast;
   assign M_axi_wvalid = w_wvalid;
   assign M_axi_bready = (r_state == ST_B);

endmodule
`default_nettype wire

// File: doc/output_layer_writer.md
# output_layer_writer

Parametrised successor to the fixed-width output-layer writer. Accepts a pixel stream from the processing core, packs pixels into AXI data beats and buffers them in an internal beat FIFO. Issues INCR write bursts to DDR3, adding a full AW/W/B handshake, short-burst handling at row ends and 4 KB boundaries, and done/error status. It sits between the convolution output FIFO and the AXI interconnect write port.

## Interface
- C_S_AXI_ID_WIDTH, 3, AXI ID width
- C_S_AXI_ADDR_WIDTH, 32, byte address width
- C_S_AXI_DATA_WIDTH, 64, beat width; multiple of PIX_WIDTH, power of two ≥ 32
- C_S_AXI_BURST_LEN, 8, maximum beats per burst (1..16)
- PIX_WIDTH, 8, pixel width; fixed at 8 so one pixel is one byte
- DIM_WIDTH, 10, width of dimension inputs
- FIFO_DEPTH, 16, beat FIFO depth; power of two ≥ C_S_AXI_BURST_LEN
- clk  in  1  clock; all logic runs on this rising edge
- reset_n  in  1  synchronous, active-low reset
- start  in  1  one-cycle pulse; latches configuration and begins a frame; ignored while busy
- base_addr  in  ADDR_WIDTH  frame byte address; must be BEAT_BYTES-aligned
- no_of_layers, row_size, col_size  in  DIM_WIDTH each  frame dimensions; col_size is a nonzero multiple of BEAT_BYTES
- s_data  in  PIX_WIDTH  pixel
- s_valid  in  1  pixel valid
- s_ready  out  1  pixel accepted when s_valid && s_ready
- busy  out  1  frame in progress
- done  out  1  one-cycle pulse after the last B response
- error  out  1  sticky; set on any bresp ≠ OKAY; cleared by start
- M_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,valid}  out, plus awready  in  standard AXI4 widths
- M_axi_w{data,strb,last,valid}  out, plus wready  in
- M_axi_bresp  in  2, M_axi_bvalid  in  1, M_axi_bready  out  1

## Operation
- BEAT_BYTES = DATA_WIDTH/8. SEG_BEATS = col_size/BEAT_BYTES.
- Input order: for each row, for each layer, col_size pixels. Each (row, layer) pair is one segment.
- Segment destination: base_addr + (layer*row_size + row)*col_size.
  - Compute with ADDR_WIDTH arithmetic and truncate on overflow.
- Packing: pixel k of a beat goes to bits [8k+7:8k], LSB-first. A beat is pushed to the FIFO when it completes.
  - Beats never straddle a segment, because col_size is a multiple of BEAT_BYTES.
- Input counters: col, layer and row wrap in that nesting order. The frame ends after row_size*no_of_layers segments.
  - s_ready is 0 once all pixels of the frame have been accepted.
- Burst length = min(C_S_AXI_BURST_LEN, beats remaining in segment, beats to the next 4 KB boundary).
- Write FSM: IDLE → AW → W → B → IDLE.
  - IDLE → AW when FIFO count ≥ computed burst length.
  - AW → W on awvalid && awready.
  - W → B on the beat where wlast && wready.
  - B → IDLE on bvalid. In B, set error if bresp ≠ 0.
  - After the last burst's B, pulse done, drop busy, return to IDLE.
- Only one burst is outstanding at a time.
- Write address advances by len*BEAT_BYTES. It reloads at each segment start from the segment address formula.
- Constant outputs:
  - awid=0, awsize=log2(BEAT_BYTES), awburst=INCR(1), awlock=0, awcache=4'b0011, awprot=0, awqos=0
  - wstrb all ones, awlen = len−1
- Degenerate frame: no_of_layers=0 or row_size=0 at start → done pulses on the next cycle and busy never rises.

## Timing
- Reset values: all valid outputs 0, bready 0, s_ready 0, busy 0, done 0, error 0, FSM IDLE, counters 0, FIFO empty.
- start → busy=1 the next cycle. s_ready can rise in the same cycle as busy.
- s_ready = busy && not all pixels accepted && FIFO not full. Pixel acceptance has no stall bubble.
- The first AW can assert 2 cycles after the beat that satisfies the IDLE condition is written into the FIFO.
- awvalid and wvalid hold with stable payload until accepted. wvalid is never asserted in AW state.
- wdata comes from the FIFO head (show-ahead). In W state, wvalid = 1 while the FIFO is nonempty.
- bready = 1 only in B state.
- Simultaneous FIFO push and pop is legal; the count is unchanged.
- Reset asserted mid-burst aborts immediately, with no completion of the AXI burst.

## Structure
- output_layer_pkg holds AXI constants: BURST_INCR, CACHE_BUFFERABLE=4'b0011, RESP_OKAY, and the FSM state enum.
- One sub-module, output_layer_beat_fifo: synchronous, show-ahead, parametrised width/depth, with count output.

## Test plan
- DATA 64, BURST 8, layers=1, rows=1, col=64, base=0x1000, pixels 0..63 → one burst: awaddr=0x1000, awlen=7; beat0 wdata=0x0706050403020100; wlast on beat 8; then done.
- col=40 → one burst with awlen=4, five beats, wlast on beat 5.
- layers=2, rows=2, col=16, base=0 → bursts at 0x00, 0x20, 0x10, 0x30 in that order, each awlen=1.
- base=0xFF0, col=64 → first burst awaddr=0xFF0 awlen=1, second awaddr=0x1000 awlen=5; no burst crosses 0x1000.
- Random wready/awready/s_valid throttling with 10% bresp=SLVERR(2) → DDR image matches the model; error=1 at done; the next start clears error.
- Assert reset_n=0 mid W beat 3 → the next cycle all valid outputs are 0 and busy=0; a new start runs a clean frame.
